axi4lite_master_arbiter: RTL and testbench
==========================================

# axi4lite_master_arbiter

Shares one `axi4lite_master` control interface between `NUM_REQ` requesters. It performs round-robin selection, launches one transaction at a time through the master's start/done handshake, and routes the completion back to the winning requester. It sits between several client engines and the single AXI4-Lite master.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; legal values are ≥2.
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.

Ports:
- `ACLK` in 1: clock. All logic is on the rising edge.
- `ARESETn` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i occupies slice i.
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data.
- `req_wstrb` in NUM_REQ*4: packed write strobes.
- `req_ready` out NUM_REQ: one-cycle accept pulse to the granted requester.
- `rsp_valid` out NUM_REQ: one-cycle completion pulse to the granted requester.
- `rsp_rdata` out DATA_WIDTH: read data, valid with `rsp_valid`.
- `rsp_resp` out 2: BRESP or RRESP, valid with `rsp_valid`.
- `m_start`, `m_write`, `m_addr`, `m_wdata`, `m_wstrb` out: drive the master's `start`, `write`, `addr`, `wdata` and `wstrb`.
- `m_busy` in 1: from the master's `busy`.
- `m_done` in 1: from the master's `done`.
- `m_rdata` in DATA_WIDTH: from the master's `rdata`.
- `m_resp` in 2: from the master's `resp`.

## Operation
The state machine has four states: `IDLE`, `START`, `WAIT` and `RESP`.

- **IDLE:** if `|req_valid` and `!m_busy`:
  - Select `grant` using round-robin starting at `rr_ptr`. The lowest index at or after `rr_ptr` wins, wrapping from NUM_REQ-1 to 0.
  - Register that requester's fields into `m_*`.
  - Set `m_start`=1 and `req_ready[grant]`=1.
  - Go to `START`.
- **START:** clear `m_start` and `req_ready`. Go to `WAIT`. `req_valid` is ignored in this state, so a requester dropping valid late cannot be accepted twice.
- **WAIT:** on `m_done`:
  - Register `rsp_rdata`←`m_rdata` and `rsp_resp`←`m_resp`.
  - Set `rsp_valid[grant]`=1.
  - Set `rr_ptr`←(grant+1) mod NUM_REQ.
  - Go to `RESP`.
- **RESP:** clear `rsp_valid`. Go to `IDLE`.

Requester rules:
- A requester holds `req_valid` and its fields stable until it sees `req_ready`.
- It may present a new request the cycle after `req_ready`. That request is considered only after the current transaction's `RESP` state.

Arithmetic and widths:
- `grant` and `rr_ptr` are $clog2(NUM_REQ) bits wide.
- The wrap is explicit, so a NUM_REQ that is not a power of two never yields an out-of-range index.

Boundary conditions:
- **All requesters valid, `rr_ptr`=2:** grant 2, then 3, then 0, then 1.
- **Only the requester just served is valid:** it is granted again; no idle gap beyond `RESP`.
- **`m_busy` high in `IDLE`:** hold in `IDLE` and issue nothing.
- **`m_done` outside `WAIT`:** ignored.
- **Reset mid-operation:**
  - State returns to `IDLE` and `rr_ptr` and `grant` clear to 0.
  - The master transaction in flight is abandoned, and its late `m_done` is ignored.
  - The master must be reset by the same `ARESETn`.

## Timing
Reset values:
- `m_start`, `req_ready`, `rsp_valid`: 0.
- `m_write`, `m_addr`, `m_wdata`, `m_wstrb`, `rsp_rdata`, `rsp_resp`: 0.
- State `IDLE`; `rr_ptr` 0.

Cycle timing:
- `req_valid` sampled at edge N → `m_start` and `req_ready` high for cycle N+1.
- `m_*` fields are stable from edge N until the next grant.
- `m_done` sampled at edge D → `rsp_valid` high for cycle D+1 → earliest next `m_start` is cycle D+3.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `AXI_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. `rr_ptr` is held at 0 and never updated.
- Undefined (default): round-robin as described above.

## Structure
- Package `axi4lite_arb_pkg` holds:
  - the state enum (`IDLE`, `START`, `WAIT`, `RESP`);
  - the response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- Sub-module `axi4lite_rr_pick` is purely combinational:
  - inputs: `req` vector and `rr_ptr`;
  - outputs: `grant` index and `any`.
  - The fixed-priority macro is applied inside this sub-module.

## Test plan
- **Single write:** req0 write addr 0x10, data 0xDEADBEEF, wstrb 0xF. `m_start` 1 cycle after `req_valid` with matching `m_*`; `m_done` with resp 00 → `rsp_valid[0]` next cycle, `rsp_resp`=00.
- **Single read:** req2 read 0x20; master returns 0x12345678, resp 00. `rsp_rdata`=0x12345678 and only `rsp_valid[2]` pulses.
- **Contention:** all 4 requesters held valid. Grant order 0,1,2,3,0. Exactly one `req_ready` pulse per grant; never two transactions outstanding. Same scenario under `AXI_ARB_FIXED_PRIO_EN`: grant order 0,0,0 while req0 stays valid.
- **Busy and spurious done:** `m_busy`=1 in `IDLE` → no `m_start`. `m_done` pulsed in `IDLE` → no `rsp_valid`.
- **Reset mid-transaction:** assert `ARESETn`=0 in `WAIT`. All outputs 0 immediately, `rr_ptr`=0. After release, req1 is served correctly.
- **Error response:** master resp 2'b10 on req3 write → `rsp_resp`=2'b10 to requester 3.

Source files
------------

// File: rtl/axi4lite_arb_pkg.sv
// Shared types for the AXI4-Lite master arbiter.
// States and AXI response codes.
package axi4lite_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam int STRB_W = 4;

endpackage

// File: rtl/axi4lite_rr_pick.sv
// Combinational requester picker; AXI_ARB_FIXED_PRIO_EN selects
// lowest-index-wins instead of round-robin from rr_ptr.
module axi4lite_rr_pick
   import axi4lite_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      rr_ptr,
   output logic [IW-1:0]      grant,
   output logic               any
);

`ifdef AXI_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^rr_ptr;

   always_comb begin
      grant = '0;
      any   = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant = IW'(i);
            any   = 1'b1;
         end
      end
   end
`else
   // Scan offsets downward so the smallest offset from rr_ptr wins.
   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      any   = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req[idx]) begin
            grant = IW'(idx);
            any   = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/axi4lite_master_arbiter.sv
// Shares one AXI4-Lite master between NUM_REQ requesters.
// Round-robin by default; AXI_ARB_FIXED_PRIO_EN gives fixed priority.
module axi4lite_master_arbiter
   import axi4lite_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                           ACLK,
   input  logic                           ARESETn,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   input  logic [NUM_REQ*STRB_W-1:0]      req_wstrb,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]          rsp_rdata,
   output logic [1:0]                     rsp_resp,
   output logic                           m_start,
   output logic                           m_write,
   output logic [ADDR_WIDTH-1:0]          m_addr,
   output logic [DATA_WIDTH-1:0]          m_wdata,
   output logic [STRB_W-1:0]              m_wstrb,
   input  logic                           m_busy,
   input  logic                           m_done,
   input  logic [DATA_WIDTH-1:0]          m_rdata,
   input  logic [1:0]                     m_resp
);

   localparam int IW = $clog2(NUM_REQ);

   arb_state_e state_q, state_d;

   logic [IW-1:0]         grant_q, grant_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]         pick_grant;
   logic                  pick_any;

   logic [NUM_REQ-1:0]    ready_d;
   logic [NUM_REQ-1:0]    rspv_d;
   logic                  start_d;
   logic                  write_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] wdata_d;
   logic [STRB_W-1:0]     wstrb_d;
   logic [DATA_WIDTH-1:0] rdata_d;
   logic [1:0]            resp_d;

   axi4lite_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr_q),
      .grant  (pick_grant),
      .any    (pick_any)
   );

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      start_d  = 1'b0;
      ready_d  = '0;
      rspv_d   = '0;
      write_d  = m_write;
      addr_d   = m_addr;
      wdata_d  = m_wdata;
      wstrb_d  = m_wstrb;
      rdata_d  = rsp_rdata;
      resp_d   = rsp_resp;

      unique case (state_q)
         IDLE: begin
            if (pick_any && !m_busy) begin
               grant_d = pick_grant;
               write_d = req_write[pick_grant];
               addr_d  = req_addr[int'(pick_grant)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d = req_wdata[int'(pick_grant)*DATA_WIDTH +: DATA_WIDTH];
               wstrb_d = req_wstrb[int'(pick_grant)*STRB_W +: STRB_W];
               start_d = 1'b1;
               ready_d = NUM_REQ'(1) << pick_grant;
               state_d = START;
            end
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (m_done) begin
               rdata_d = m_rdata;
               resp_d  = m_resp;
               rspv_d  = NUM_REQ'(1) << grant_q;
`ifndef AXI_ARB_FIXED_PRIO_EN
               // Explicit wrap keeps non-power-of-two counts in range.
               if (grant_q == IW'(NUM_REQ - 1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = grant_q + 1'b1;
               end
`endif
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         m_start   <= 1'b0;
         req_ready <= '0;
         rsp_valid <= '0;
         m_write   <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         m_wstrb   <= '0;
         rsp_rdata <= '0;
         rsp_resp  <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         m_start   <= start_d;
         req_ready <= ready_d;
         rsp_valid <= rspv_d;
         m_write   <= write_d;
         m_addr    <= addr_d;
         m_wdata   <= wdata_d;
         m_wstrb   <= wstrb_d;
         rsp_rdata <= rdata_d;
         rsp_resp  <= resp_d;
      end
   end

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// Randomized bench for axi4lite_master_arbiter with a queue-free
// arbitration model; honours AXI_ARB_FIXED_PRIO_EN when defined.
module tb_axi4lite_master_arbiter;
   import axi4lite_arb_pkg::*;

   localparam int N = 4;

   logic          ACLK;
   logic          ARESETn;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_write;
   logic [N*32-1:0] req_addr;
   logic [N*32-1:0] req_wdata;
   logic [N*4-1:0]  req_wstrb;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  rsp_valid;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          m_start;
   logic          m_write;
   logic [31:0]   m_addr;
   logic [31:0]   m_wdata;
   logic [3:0]    m_wstrb;
   logic          m_busy;
   logic          m_done;
   logic [31:0]   m_rdata;
   logic [1:0]    m_resp;

   axi4lite_master_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32)
   ) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .m_start   (m_start),
      .m_write   (m_write),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_busy    (m_busy),
      .m_done    (m_done),
      .m_rdata   (m_rdata),
      .m_resp    (m_resp)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      int          g;
      int          rdy_cnt;
      int          wait_n;
      int          extra;
      bit          to;
      logic        mw;
      logic [31:0] ma;
      logic [31:0] mwd;
      logic [3:0]  mst;
      logic [3:0]  rspv;
      logic [3:0]  rspv2;
      logic [31:0] rrd;
      logic [1:0]  rrs;
   } obs_t;

   int vectors;
   int miscompares;
   int model_ptr;

   logic        t_write [N];
   logic [31:0] t_addr  [N];
   logic [31:0] t_wdata [N];
   logic [3:0]  t_wstrb [N];

   function automatic int model_pick(input logic [N-1:0] v, input int ptr);
      int p;
`ifdef AXI_ARB_FIXED_PRIO_EN
      p = 0;
`else
      p = ptr;
`endif
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_served(input int g);
`ifndef AXI_ARB_FIXED_PRIO_EN
      model_ptr = (g + 1) % N;
`endif
   endtask

   task automatic drive_req(input int i, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      t_write[i] = w;
      t_addr[i]  = a;
      t_wdata[i] = d;
      t_wstrb[i] = s;
      req_write[i]         = w;
      req_addr[i*32 +: 32] = a;
      req_wdata[i*32 +: 32] = d;
      req_wstrb[i*4 +: 4]  = s;
      req_valid[i]         = 1'b1;
   endtask

   task automatic apply_reset();
      ARESETn   = 1'b0;
      req_valid = '0;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_rdata   = '0;
      m_resp    = '0;
      repeat (3) @(negedge ACLK);
      ARESETn   = 1'b1;
      model_ptr = 0;
      @(negedge ACLK);
   endtask

   // Plays the requester and master sides of one transaction.
   task automatic serve_one(input bit keep, input int lat, input logic [31:0] rd,
                            input logic [1:0] rs, output obs_t o);
      o = '{default: 0};
      o.g = -1;
      do begin
         @(negedge ACLK);
         o.wait_n++;
      end while (!m_start && o.wait_n < 20);
      if (!m_start) begin
         o.to = 1'b1;
         return;
      end
      o.rdy_cnt = $countones(req_ready);
      for (int i = 0; i < N; i++) if (req_ready[i]) o.g = i;
      o.mw  = m_write;
      o.ma  = m_addr;
      o.mwd = m_wdata;
      o.mst = m_wstrb;
      if (!keep && o.g >= 0) req_valid[o.g] = 1'b0;
      m_busy = 1'b1;
      repeat (lat) begin
         @(negedge ACLK);
         if (m_start) o.extra++;
         if (|req_ready) o.extra++;
      end
      m_done  = 1'b1;
      m_rdata = rd;
      m_resp  = rs;
      m_busy  = 1'b0;
      @(negedge ACLK);
      m_done  = 1'b0;
      o.rspv  = rsp_valid;
      o.rrd   = rsp_rdata;
      o.rrs   = rsp_resp;
      @(negedge ACLK);
      o.rspv2 = rsp_valid;
   endtask

   task automatic test_reset();
      ARESETn = 1'b0;
      #1;
      vectors++;
      if ({m_start, req_ready, rsp_valid} !== 9'b0) begin
         miscompares++;
         $display("FAIL reset_pulses: got %b expected 0", {m_start, req_ready, rsp_valid});
      end
      vectors++;
      if ({m_write, m_addr, m_wdata, m_wstrb, rsp_rdata, rsp_resp} !== 103'b0) begin
         miscompares++;
         $display("FAIL reset_fields: got addr=%h wdata=%h rdata=%h expected 0",
                  m_addr, m_wdata, rsp_rdata);
      end
      apply_reset();
   endtask

   task automatic test_single_write();
      obs_t o;
      int eg;
      drive_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      eg = model_pick(req_valid, model_ptr);
      serve_one(1'b0, 2, 32'h0, OKAY, o);
      vectors++;
      if (o.g !== eg || o.wait_n != 1 || o.rdy_cnt != 1) begin
         miscompares++;
         $display("FAIL write_grant: got g=%0d wait=%0d rdy=%0d expected g=%0d wait=1 rdy=1",
                  o.g, o.wait_n, o.rdy_cnt, eg);
      end
      vectors++;
      if ({o.mw, o.ma, o.mwd, o.mst} !== {1'b1, 32'h10, 32'hDEADBEEF, 4'hF}) begin
         miscompares++;
         $display("FAIL write_fields: got w=%b a=%h d=%h s=%h expected 1 10 deadbeef f",
                  o.mw, o.ma, o.mwd, o.mst);
      end
      vectors++;
      if (o.rspv !== 4'b0001 || o.rrs !== OKAY || o.rspv2 !== 4'b0) begin
         miscompares++;
         $display("FAIL write_rsp: got v=%b then %b resp=%b expected 0001 then 0000 resp=00",
                  o.rspv, o.rspv2, o.rrs);
      end
      model_served(eg);
   endtask

   task automatic test_single_read();
      obs_t o;
      int eg;
      drive_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
      eg = model_pick(req_valid, model_ptr);
      serve_one(1'b0, 3, 32'h12345678, OKAY, o);
      vectors++;
      if (o.g !== eg || o.mw !== 1'b0 || o.ma !== 32'h20) begin
         miscompares++;
         $display("FAIL read_grant: got g=%0d w=%b a=%h expected g=%0d w=0 a=20",
                  o.g, o.mw, o.ma, eg);
      end
      vectors++;
      if (o.rspv !== 4'b0100 || o.rrd !== 32'h12345678 || o.rrs !== OKAY) begin
         miscompares++;
         $display("FAIL read_rsp: got v=%b d=%h r=%b expected 0100 12345678 00",
                  o.rspv, o.rrd, o.rrs);
      end
      model_served(eg);
   endtask

   task automatic test_contention();
      obs_t o;
      int eg;
      apply_reset();
      for (int i = 0; i < N; i++) drive_req(i, i[0], 32'h100 + i, 32'hA0 + i, 4'(i + 1));
      for (int n = 0; n < 9; n++) begin
         eg = model_pick(req_valid, model_ptr);
         serve_one(1'b1, 1 + (n % 3), 32'hC0DE0000 + n, OKAY, o);
         vectors++;
         if (o.g !== eg || o.rdy_cnt != 1 || o.extra != 0 || o.wait_n != 1 || o.to) begin
            miscompares++;
            $display("FAIL contention_%0d: got g=%0d rdy=%0d extra=%0d wait=%0d expected g=%0d",
                     n, o.g, o.rdy_cnt, o.extra, o.wait_n, eg);
         end
         vectors++;
         if (o.ma !== 32'h100 + eg || o.rspv !== 4'(1) << eg || o.rrd !== 32'hC0DE0000 + n) begin
            miscompares++;
            $display("FAIL contention_rsp_%0d: got a=%h v=%b d=%h", n, o.ma, o.rspv, o.rrd);
         end
         model_served(eg);
      end
      req_valid = '0;
      @(negedge ACLK);
   endtask

   task automatic test_busy_spurious();
      obs_t o;
      int eg;
      logic seen;
      m_busy = 1'b1;
      drive_req(1, 1'b1, 32'h44, 32'h5555AAAA, 4'h3);
      seen = 1'b0;
      repeat (5) begin
         @(negedge ACLK);
         seen = seen | m_start | (|req_ready);
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_hold: got start/ready=%b expected 0", seen);
      end
      m_done = 1'b1;
      m_rdata = 32'hBAD0BAD0;
      @(negedge ACLK);
      m_done = 1'b0;
      seen = rsp_valid != 0;
      @(negedge ACLK);
      seen = seen | (rsp_valid != 0);
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL spurious_done: got rsp_valid pulse expected none");
      end
      m_busy = 1'b0;
      eg = model_pick(req_valid, model_ptr);
      serve_one(1'b0, 1, 32'h0, EXOKAY, o);
      vectors++;
      if (o.g !== eg || o.wait_n != 1 || o.rspv !== 4'(1) << eg || o.rrs !== EXOKAY) begin
         miscompares++;
         $display("FAIL busy_release: got g=%0d wait=%0d v=%b r=%b expected g=%0d",
                  o.g, o.wait_n, o.rspv, o.rrs, eg);
      end
      model_served(eg);
   endtask

   task automatic test_reset_mid();
      obs_t o;
      int eg;
      int w;
      drive_req(2, 1'b1, 32'h88, 32'h01020304, 4'hC);
      w = 0;
      do begin
         @(negedge ACLK);
         w++;
      end while (!m_start && w < 20);
      vectors++;
      if (!m_start) begin
         miscompares++;
         $display("FAIL reset_mid_start: got no m_start expected one");
      end
      req_valid = '0;
      m_busy = 1'b1;
      @(negedge ACLK);
      ARESETn = 1'b0;
      m_busy = 1'b0;
      #1;
      vectors++;
      if ({m_start, req_ready, rsp_valid, m_write, m_addr, m_wdata, m_wstrb} !== 78'b0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got a=%h d=%h s=%h expected 0",
                  m_addr, m_wdata, m_wstrb);
      end
      @(negedge ACLK);
      ARESETn = 1'b1;
      model_ptr = 0;
      @(negedge ACLK);
      m_done = 1'b1;
      @(negedge ACLK);
      m_done = 1'b0;
      w = int'(rsp_valid != 0);
      @(negedge ACLK);
      w = w + int'(rsp_valid != 0);
      vectors++;
      if (w != 0) begin
         miscompares++;
         $display("FAIL late_done: got %0d rsp pulses expected 0", w);
      end
      drive_req(1, 1'b0, 32'h1234, 32'h0, 4'h0);
      drive_req(3, 1'b1, 32'h3333, 32'h77, 4'h1);
      for (int n = 0; n < 2; n++) begin
         eg = model_pick(req_valid, model_ptr);
         serve_one(1'b0, 2, 32'hFACE0000 + n, OKAY, o);
         vectors++;
         if (o.g !== eg || o.ma !== t_addr[eg] || o.rspv !== 4'(1) << eg ||
             o.rrd !== 32'hFACE0000 + n) begin
            miscompares++;
            $display("FAIL reset_recover_%0d: got g=%0d a=%h v=%b expected g=%0d",
                     n, o.g, o.ma, o.rspv, eg);
         end
         model_served(eg);
      end
   endtask

   task automatic test_error_resp();
      obs_t o;
      int eg;
      drive_req(3, 1'b1, 32'hE0, 32'hCAFEF00D, 4'h6);
      eg = model_pick(req_valid, model_ptr);
      serve_one(1'b0, 2, 32'h0, SLVERR, o);
      vectors++;
      if (o.g !== eg || o.rspv !== 4'b1000 || o.rrs !== SLVERR) begin
         miscompares++;
         $display("FAIL error_resp: got g=%0d v=%b r=%b expected g=3 1000 10",
                  o.g, o.rspv, o.rrs);
      end
      model_served(eg);
   endtask

   task automatic test_random();
      obs_t o;
      int eg;
      int lat;
      logic [31:0] rd;
      logic [1:0] rs;
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1)
               drive_req(i, 1'($urandom), $urandom, $urandom, 4'($urandom));
         end
         if (req_valid == '0) begin
            eg = $urandom_range(0, N - 1);
            drive_req(eg, 1'($urandom), $urandom, $urandom, 4'($urandom));
         end
         eg  = model_pick(req_valid, model_ptr);
         lat = $urandom_range(1, 4);
         rd  = $urandom;
         rs  = 2'($urandom);
         serve_one(1'b0, lat, rd, rs, o);
         req_valid[eg] = 1'b0;
         vectors++;
         if (o.g !== eg || o.rdy_cnt != 1 || o.extra != 0 || o.wait_n != 1 || o.to) begin
            miscompares++;
            $display("FAIL random_grant_%0d: got g=%0d rdy=%0d extra=%0d wait=%0d expected g=%0d",
                     n, o.g, o.rdy_cnt, o.extra, o.wait_n, eg);
         end
         vectors++;
         if ({o.mw, o.ma, o.mwd, o.mst} !==
             {t_write[eg], t_addr[eg], t_wdata[eg], t_wstrb[eg]}) begin
            miscompares++;
            $display("FAIL random_fields_%0d: got w=%b a=%h d=%h s=%h expected %b %h %h %h",
                     n, o.mw, o.ma, o.mwd, o.mst,
                     t_write[eg], t_addr[eg], t_wdata[eg], t_wstrb[eg]);
         end
         vectors++;
         if (o.rspv !== 4'(1) << eg || o.rrd !== rd || o.rrs !== rs || o.rspv2 !== 4'b0) begin
            miscompares++;
            $display("FAIL random_rsp_%0d: got v=%b d=%h r=%b expected g=%0d d=%h r=%b",
                     n, o.rspv, o.rrd, o.rrs, eg, rd, rs);
         end
         model_served(eg);
      end
      req_valid = '0;
      @(negedge ACLK);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_ptr   = 0;
      ARESETn     = 1'b0;
      req_valid   = '0;
      req_write   = '0;
      req_addr    = '0;
      req_wdata   = '0;
      req_wstrb   = '0;
      m_busy      = 1'b0;
      m_done      = 1'b0;
      m_rdata     = '0;
      m_resp      = '0;
      for (int i = 0; i < N; i++) begin
         t_write[i] = 1'b0;
         t_addr[i]  = '0;
         t_wdata[i] = '0;
         t_wstrb[i] = '0;
      end
      test_reset();
      test_single_write();
      test_single_read();
      test_contention();
      test_busy_spurious();
      test_reset_mid();
      test_error_resp();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
